// File: rtl/iir_sos_cascade.sv
`default_nettype none
// ============================================================================
// Module      : iir_sos_cascade
// Description : Cascade of N_SEC Direct-Form-I biquad sections sharing one
//               multiplier. Runtime-loadable coefficients, valid/ready sample
//               handshake, history clear. Round-half-up, saturating sections.
// Revision    : 1.0 - initial release
// ============================================================================
module iir_sos_cascade #(
    parameter int WD_IN   = 24,
    parameter int WD_OUT  = 24,
    parameter int WD_COEF = 18,
    parameter int FRAC    = 16,
    parameter int N_SEC   = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WD_IN-1:0]             data_in,
    output logic                         out_valid,
    output logic [WD_OUT-1:0]            data_out,
    input  logic                         coef_we,
    input  logic [$clog2(5*N_SEC)-1:0]   coef_addr,
    input  logic [WD_COEF-1:0]           coef_wdata,
    input  logic                         clear_hist
);

    localparam int N_COEF = 5 * N_SEC;
    localparam int ADDR_W = $clog2(N_COEF);
    localparam int SEC_W  = (N_SEC > 1) ? $clog2(N_SEC) : 1;
    localparam int PROD_W = WD_IN + WD_COEF;
    localparam int ACC_W  = PROD_W + 3;

    localparam logic signed [ACC_W-1:0]   ROUND    = ACC_W'(64'sd1 <<< (FRAC - 1));
    localparam logic signed [ACC_W-1:0]   SAT_MAX  = ACC_W'((64'sd1 <<< (WD_IN - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0]   SAT_MIN  = ~SAT_MAX;
    localparam logic signed [WD_COEF-1:0] B0_RESET = WD_COEF'(64'sd1 <<< FRAC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_SCALE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state, state_next;

    logic        [2:0]         tap;
    logic        [SEC_W-1:0]   sec;
    logic signed [WD_IN-1:0]   x_cur;
    logic signed [ACC_W-1:0]   acc;

    logic signed [WD_IN-1:0]   hx1 [N_SEC];
    logic signed [WD_IN-1:0]   hx2 [N_SEC];
    logic signed [WD_IN-1:0]   hy1 [N_SEC];
    logic signed [WD_IN-1:0]   hy2 [N_SEC];
    logic signed [WD_COEF-1:0] coef [N_COEF];

    logic        [ADDR_W-1:0]  coef_idx;
    logic signed [WD_IN-1:0]   mul_x;
    logic signed [WD_COEF-1:0] mul_c;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   acc_next;
    logic signed [ACC_W-1:0]   rounded;
    logic signed [ACC_W-1:0]   shifted;
    logic signed [WD_IN-1:0]   y_sat;
    logic                      accept;
    logic                      coef_addr_ok;
    logic                      last_sec;

    assign in_ready     = (state == S_IDLE) && reset_n;
    assign accept       = in_ready && in_valid;
    assign coef_addr_ok = (32'(coef_addr) < N_COEF);
    assign last_sec     = (32'(sec) == N_SEC - 1);
    assign coef_idx     = ADDR_W'(32'(sec) * 5 + 32'(tap));

    // Operand select for the shared multiplier: tap order b0 x, b1 x1, b2 x2, a1 y1, a2 y2
    always_comb begin
        mul_x = '0;
        mul_c = coef[coef_idx];
        case (tap)
            3'd0:    mul_x = x_cur;
            3'd1:    mul_x = hx1[sec];
            3'd2:    mul_x = hx2[sec];
            3'd3:    mul_x = hy1[sec];
            3'd4:    mul_x = hy2[sec];
            default: mul_c = '0;
        endcase
    end

    // Exact product; feed-forward taps add, feedback taps subtract
    assign prod     = PROD_W'(mul_x) * PROD_W'(mul_c);
    assign acc_next = (tap < 3'd3) ? (acc + ACC_W'(prod)) : (acc - ACC_W'(prod));

    // Round half up, arithmetic shift, then clamp to the sample range
    assign rounded = acc + ROUND;
    assign shifted = rounded >>> FRAC;

    // Saturate the section result instead of wrapping
    always_comb begin
        y_sat = shifted[WD_IN-1:0];
        if (shifted > SAT_MAX) begin
            y_sat = SAT_MAX[WD_IN-1:0];
        end else if (shifted < SAT_MIN) begin
            y_sat = SAT_MIN[WD_IN-1:0];
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: five MAC cycles then one SCALE cycle per section
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = S_MAC;
            S_MAC:   if (tap == 3'd4) state_next = S_SCALE;
            S_SCALE: state_next = last_sec ? S_DONE : S_MAC;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Coefficient store: identity filter after reset, writable only while idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_COEF; i++) begin
                coef[i] <= (i % 5 == 0) ? B0_RESET : '0;
            end
        end else if (coef_we && in_ready && coef_addr_ok) begin
            coef[coef_addr] <= coef_wdata;
        end
    end

    // Datapath: sample latch, accumulate, per-section history and result output
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tap       <= '0;
            sec       <= '0;
            x_cur     <= '0;
            acc       <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            for (int s = 0; s < N_SEC; s++) begin
                hx1[s] <= '0;
                hx2[s] <= '0;
                hy1[s] <= '0;
                hy2[s] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (clear_hist) begin
                        for (int s = 0; s < N_SEC; s++) begin
                            hx1[s] <= '0;
                            hx2[s] <= '0;
                            hy1[s] <= '0;
                            hy2[s] <= '0;
                        end
                    end
                    if (accept) begin
                        x_cur <= data_in;
                        acc   <= '0;
                        sec   <= '0;
                        tap   <= '0;
                    end
                end
                S_MAC: begin
                    acc <= acc_next;
                    tap <= (tap == 3'd4) ? 3'd0 : tap + 3'd1;
                end
                S_SCALE: begin
                    hx2[sec] <= hx1[sec];
                    hx1[sec] <= x_cur;
                    hy2[sec] <= hy1[sec];
                    hy1[sec] <= y_sat;
                    x_cur    <= y_sat;
                    acc      <= '0;
                    tap      <= '0;
                    if (!last_sec) begin
                        sec <= sec + SEC_W'(1);
                    end
                end
                S_DONE: begin
                    data_out  <= WD_OUT'(x_cur);
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iir_sos_cascade.sv
`default_nettype none
// ============================================================================
// Module      : tb_iir_sos_cascade
// Description : Scoreboard bench for iir_sos_cascade with a behavioural
//               cascade model; directed cases plus randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iir_sos_cascade;

    localparam int WD_IN   = 24;
    localparam int WD_OUT  = 24;
    localparam int WD_COEF = 18;
    localparam int FRAC    = 16;
    localparam int N_SEC   = 2;
    localparam int N_COEF  = 5 * N_SEC;
    localparam int LAT     = 6 * N_SEC + 1;
    localparam longint MAXV = (longint'(1) <<< (WD_IN - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (WD_IN - 1));

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] data_in;
    logic        out_valid;
    logic [23:0] data_out;
    logic        coef_we;
    logic [3:0]  coef_addr;
    logic [17:0] coef_wdata;
    logic        clear_hist;

    iir_sos_cascade #(
        .WD_IN(WD_IN), .WD_OUT(WD_OUT), .WD_COEF(WD_COEF), .FRAC(FRAC), .N_SEC(N_SEC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .out_valid(out_valid), .data_out(data_out),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .clear_hist(clear_hist)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        longint data;
        int     cyc;
    } exp_t;
    exp_t sb[$];

    // Behavioural model state
    longint mc  [N_COEF];
    longint hx1 [N_SEC];
    longint hx2 [N_SEC];
    longint hy1 [N_SEC];
    longint hy2 [N_SEC];

    function automatic logic signed [63:0] sx24(input logic [23:0] v);
        return {{40{v[23]}}, v};
    endfunction

    function automatic longint sx18(input logic [17:0] v);
        return longint'({{46{v[17]}}, v});
    endfunction

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic void model_clear();
        for (int s = 0; s < N_SEC; s++) begin
            hx1[s] = 0; hx2[s] = 0; hy1[s] = 0; hy2[s] = 0;
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N_COEF; i++) mc[i] = (i % 5 == 0) ? (longint'(1) <<< FRAC) : 0;
        model_clear();
    endfunction

    // Difference equation per section: y = b0 x + b1 x1 + b2 x2 - a1 y1 - a2 y2, scaled, rounded, clamped
    function automatic longint model_step(input longint x_in);
        longint x, acc, y;
        x = x_in;
        for (int s = 0; s < N_SEC; s++) begin
            acc = mc[5*s] * x + mc[5*s+1] * hx1[s] + mc[5*s+2] * hx2[s]
                - mc[5*s+3] * hy1[s] - mc[5*s+4] * hy2[s];
            y = (acc + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
            if (y > MAXV) y = MAXV;
            if (y < MINV) y = MINV;
            hx2[s] = hx1[s]; hx1[s] = x;
            hy2[s] = hy1[s]; hy1[s] = y;
            x = y;
        end
        return x;
    endfunction

    // Monitor: every out_valid pops one expectation and checks value and latency
    always @(negedge clk) begin
        exp_t e;
        if (reset_n === 1'b1 && out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_out_valid: got data_out 0x%0h with no sample pending at cycle %0d",
                         data_out, cyc);
            end else begin
                e = sb.pop_front();
                check("data_out", sx24(data_out), e.data);
                check("latency", cyc, e.cyc);
            end
        end
    end

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_fail++;
            $display("FAIL ready_timeout: in_ready still %b, required 1 within 200 cycles", in_ready);
        end
    endtask

    task automatic send(input logic [23:0] x, input bit clr, input bit use_lit, input logic [23:0] lit);
        bit     ok;
        longint m;
        exp_t   e;
        wait_ready(ok);
        if (!ok) return;
        in_valid   = 1'b1;
        data_in    = x;
        clear_hist = clr;
        if (clr) model_clear();
        m = model_step(sx24(x));
        @(posedge clk);
        #1;
        e.data = use_lit ? sx24(lit) : m;
        e.cyc  = cyc + LAT;
        sb.push_back(e);
        in_valid   = 1'b0;
        clear_hist = 1'b0;
    endtask

    task automatic lit_send(input logic [23:0] x, input logic [23:0] lit);
        send(x, 1'b0, 1'b1, lit);
    endtask

    task automatic write_coef(input logic [3:0] addr, input logic [17:0] val, input bit idle);
        bit ok;
        if (idle) begin
            wait_ready(ok);
            if (!ok) return;
        end else begin
            @(negedge clk);
        end
        coef_we    = 1'b1;
        coef_addr  = addr;
        coef_wdata = val;
        if (idle && addr < N_COEF) mc[addr] = sx18(val);
        @(posedge clk);
        #1;
        coef_we = 1'b0;
    endtask

    task automatic pulse_clear();
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        clear_hist = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        clear_hist = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int v;
        reset_n    = 1'b0;
        in_valid   = 1'b0;
        data_in    = '0;
        coef_we    = 1'b0;
        coef_addr  = '0;
        coef_wdata = '0;
        clear_hist = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_data_out", sx24(data_out), 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);

        // Identity after reset
        lit_send(24'h000100, 24'h000100);
        lit_send(24'hFFFF00, 24'hFFFF00);
        lit_send(24'h7FFFFF, 24'h7FFFFF);
        drain();

        // Writes while busy or out of range are ignored
        lit_send(24'h000200, 24'h000200);
        write_coef(4'd0, 18'h08000, 1'b0);
        write_coef(4'd3, 18'h38000, 1'b0);
        lit_send(24'h000300, 24'h000300);
        write_coef(4'd10, 18'h08000, 1'b1);
        lit_send(24'h000400, 24'h000400);
        drain();

        // First-order recursion in section 0: step response
        write_coef(4'd3, 18'h38000, 1'b1);
        pulse_clear();
        lit_send(24'h001000, 24'h001000);
        lit_send(24'h001000, 24'h001800);
        lit_send(24'h001000, 24'h001C00);
        lit_send(24'h001000, 24'h001E00);
        drain();

        // History clear restarts the step; clear coinciding with a sample
        pulse_clear();
        lit_send(24'h001000, 24'h001000);
        lit_send(24'h001000, 24'h001800);
        lit_send(24'h001000, 24'h001C00);
        pulse_clear();
        lit_send(24'h001000, 24'h001000);
        lit_send(24'h001000, 24'h001800);
        send(24'h001000, 1'b1, 1'b1, 24'h001000);
        drain();

        // Saturation at both rails
        write_coef(4'd3, 18'h00000, 1'b1);
        write_coef(4'd0, 18'h1FFFF, 1'b1);
        pulse_clear();
        lit_send(24'h7FFFFF, 24'h7FFFFF);
        lit_send(24'h800000, 24'h800000);
        drain();

        // Randomized coefficients, samples, clears and writes
        for (int i = 0; i < N_COEF; i++) begin
            v = int'($urandom_range(0, 2 * 32'hC000)) - 32'hC000;
            write_coef(4'(i), v[17:0], 1'b1);
        end
        for (int n = 0; n < 40; n++) begin
            logic [23:0] x;
            x = 24'($urandom);
            if ($urandom_range(0, 1) == 0) x = {{8{x[15]}}, x[15:0]};
            if ($urandom_range(0, 9) == 0) begin
                v = int'($urandom_range(0, 2 * 32'hC000)) - 32'hC000;
                write_coef(4'($urandom_range(0, 15)), v[17:0], 1'b1);
            end
            send(x, ($urandom_range(0, 7) == 0), 1'b0, 24'h0);
        end
        drain();

        // Reset mid-MAC aborts the sample and restores identity
        send(24'h001234, 1'b0, 1'b0, 24'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        sb.delete();
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_data_out", sx24(data_out), 0);
        check("abort_in_ready", in_ready, 0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        repeat (20) @(negedge clk);
        check("post_abort_data_out", sx24(data_out), 0);
        lit_send(24'h0ABCDE, 24'h0ABCDE);
        lit_send(24'hF54321, 24'hF54321);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
